cell_pos_streamer: RTL

- Sequencer that sits directly downstream of one per-cell position memory (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz,posy,posx}).
- On a start pulse it reads the count, then streams every particle position of the cell to the force-evaluation / motion-update pipeline over a valid/ready interface.
- It absorbs the memory's fixed latency with credit-based flow control, so downstream backpressure never drops a read.

---
 rtl/md_pos_pkg.sv | 24 ++
 rtl/pos_stream_fifo.sv | 56 +++++
 rtl/cell_pos_streamer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/md_pos_pkg.sv
// Shared types and constants for the per-cell particle position streamer.
package md_pos_pkg;

  localparam int unsigned POS_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH     = 3 * POS_WIDTH;
  localparam int unsigned ADDR_WIDTH     = 8;
  localparam int unsigned MEM_RD_LATENCY = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StWaitCnt,
    StStream,
    StDrain,
    StDone
  } stream_state_e;

  typedef struct packed {
    logic [POS_WIDTH-1:0] z;
    logic [POS_WIDTH-1:0] y;
    logic [POS_WIDTH-1:0] x;
  } pos_t;

endpackage

// File: rtl/pos_stream_fifo.sv
// Small synchronous FIFO holding {last, id, pos} beats; output is driven straight from
// storage registers so downstream sees no combinational path from push/pop.
module pos_stream_fifo #(
  parameter int unsigned Width = 105,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] store_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (count_q != CntW'(Depth));
  assign rdata_o = store_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        store_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q          <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cell_pos_streamer.sv
// Reads the particle count of one cell memory, then streams every position downstream with
// credit-based read issue. Optional stall counter: CELL_POS_STREAMER_STALL_CNT_EN.
module cell_pos_streamer
  import md_pos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = md_pos_pkg::DATA_WIDTH,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = md_pos_pkg::ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
`ifdef CELL_POS_STREAMER_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  count_err
);

  localparam int unsigned FifoW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CommW = CntW + 2;
  localparam logic [ADDR_WIDTH-1:0] MaxN = ADDR_WIDTH'(PARTICLE_NUM - 1);

  stream_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d, next_addr_q, next_addr_d, mem_addr_q, mem_addr_d, n_raw;
  logic                  mem_rden_q, mem_rden_d, count_err_q, count_err_d;
  logic [MEM_RD_LATENCY-1:0]                 infl_q;
  logic [MEM_RD_LATENCY-1:0][ADDR_WIDTH-1:0] id_pipe_q;

  logic                  ret, push, pop, issue_ok;
  logic [ADDR_WIDTH-1:0] ret_id;
  logic [FifoW-1:0]      fifo_wdata, fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  logic [CommW-1:0]      committed;

  assign ret        = infl_q[MEM_RD_LATENCY-1];
  assign ret_id     = id_pipe_q[MEM_RD_LATENCY-1];
  // Address 0 is the count word; it never enters the FIFO.
  assign push       = ret && (ret_id != '0);
  assign pop        = out_valid && out_ready;
  assign fifo_wdata = {(ret_id == n_q), ret_id, mem_q};

  pos_stream_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .valid_o (out_valid),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign out_last    = fifo_rdata[FifoW-1];
  assign out_id      = fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
  assign out_pos     = fifo_rdata[DATA_WIDTH-1:0];
  assign mem_address = mem_addr_q;
  assign mem_rden    = mem_rden_q;
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign count_err   = count_err_q;

  // Every slot the FIFO will need next cycle: occupancy plus reads on the bus and in flight.
  always_comb begin
    committed = CommW'(fifo_count) + CommW'(mem_rden_q);
    for (int unsigned i = 0; i < MEM_RD_LATENCY; i++) begin
      committed = committed + CommW'(infl_q[i]);
    end
    committed = committed - CommW'(pop);
    issue_ok  = (committed < CommW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    next_addr_d = next_addr_q;
    mem_rden_d  = 1'b0;
    mem_addr_d  = '0;
    count_err_d = count_err_q;
    n_raw       = mem_q[ADDR_WIDTH-1:0];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRdCnt;
          mem_rden_d  = 1'b1;
          count_err_d = 1'b0;
        end
      end
      StRdCnt: state_d = StWaitCnt;
      StWaitCnt: begin
        if (ret) begin
          if (n_raw > MaxN) begin
            count_err_d = 1'b1;
            n_d         = MaxN;
          end else begin
            n_d = n_raw;
          end
          if (n_d == '0) begin
            state_d = StDone;
          end else begin
            mem_rden_d  = 1'b1;
            mem_addr_d  = ADDR_WIDTH'(1);
            next_addr_d = ADDR_WIDTH'(2);
            state_d     = (n_d == ADDR_WIDTH'(1)) ? StDrain : StStream;
          end
        end
      end
      StStream: begin
        if (issue_ok) begin
          mem_rden_d  = 1'b1;
          mem_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          if (next_addr_q == n_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      next_addr_q <= '0;
      mem_rden_q  <= 1'b0;
      mem_addr_q  <= '0;
      count_err_q <= 1'b0;
      infl_q      <= '0;
      id_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      next_addr_q  <= next_addr_d;
      mem_rden_q   <= mem_rden_d;
      mem_addr_q   <= mem_addr_d;
      count_err_q  <= count_err_d;
      infl_q[0]    <= mem_rden_q;
      id_pipe_q[0] <= mem_addr_q;
      for (int unsigned i = 1; i < MEM_RD_LATENCY; i++) begin
        infl_q[i]    <= infl_q[i-1];
        id_pipe_q[i] <= id_pipe_q[i-1];
      end
    end
  end

`ifdef CELL_POS_STREAMER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StIdle) && start) begin
      stall_cnt_d = '0;
    end else if (busy && out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
